rpn_stack_ctrl: RTL



---
 rtl/calc_pkg.sv | 21 ++
 rtl/calc_stack_mem.sv | 42 ++++
 rtl/rpn_stack_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: default data width, one-hot ALU op codes and controller states.
package calc_pkg;

    localparam int unsigned CALC_DATA_W = 32;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b1000;

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    function automatic logic op_is_onehot(input logic [3:0] op);
        return $onehot(op);
    endfunction

endpackage

// File: rtl/calc_stack_mem.sv
// Operand stack storage: DEPTH x DATA_W registers, one write port, combinational reads of
// the top entry (count-1) and the entry below it (count-2).
module calc_stack_mem
    import calc_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = CALC_DATA_W,
    parameter int unsigned AW     = $clog2(DEPTH),
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [CNT_W-1:0]  i_count,
    output logic [DATA_W-1:0] o_rd_top,
    output logic [DATA_W-1:0] o_rd_next
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     w_top_idx;
    logic [AW-1:0]     w_next_idx;

    // Indices wrap when count is below 1 or 2; callers ignore those reads.
    assign w_top_idx  = AW'(i_count - CNT_W'(1));
    assign w_next_idx = AW'(i_count - CNT_W'(2));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rd_top  = r_mem[w_top_idx];
    assign o_rd_next = r_mem[w_next_idx];

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN operand/result sequencer: pushes operands, feeds top two entries to the ALU and pushes Y back.
// Optional divide-by-zero trap enabled with `define RPN_DIV0_TRAP_EN (adds err_div0).
module rpn_stack_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = CALC_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_push,
    input  logic [DATA_W-1:0]      cmd_data,
    input  logic [3:0]             cmd_op,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [3:0]             alu_op,
    input  logic [DATA_W-1:0]      alu_y,
    input  logic                   alu_ovf,
    output logic [DATA_W-1:0]      top,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf_flag,
    output logic                   err_underflow,
    output logic                   err_full,
`ifdef RPN_DIV0_TRAP_EN
    output logic                   err_div0,
`endif
    output logic                   err_badop
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] TWO_CNT  = CNT_W'(2);

    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [3:0]        r_alu_op;
    logic              r_ovf;
    logic              r_err_underflow;
    logic              r_err_full;
    logic              r_err_badop;
`ifdef RPN_DIV0_TRAP_EN
    logic              r_err_div0;
    logic              w_div0;
`endif

    logic [DATA_W-1:0] w_rd_top;
    logic [DATA_W-1:0] w_rd_next;
    logic              w_bad;
    logic              w_under;
    logic              w_push_ok;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [DATA_W-1:0] w_wdata;

    always_comb begin
        w_bad     = !op_is_onehot(cmd_op);
        w_under   = (r_count < TWO_CNT);
        w_push_ok = (r_state == IDLE) && cmd_valid && cmd_push && (r_count != FULL_CNT);
`ifdef RPN_DIV0_TRAP_EN
        w_div0    = (cmd_op == OP_DIV) && (w_rd_top == '0);
`endif
        // EXEC overwrites the A slot with Y; IDLE pushes land one past the top.
        w_we      = w_push_ok || (r_state == EXEC);
        w_waddr   = (r_state == EXEC) ? AW'(r_count - TWO_CNT) : AW'(r_count);
        w_wdata   = (r_state == EXEC) ? alu_y : cmd_data;
    end

    calc_stack_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW),
        .CNT_W  (CNT_W)
    ) u_mem (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_count   (r_count),
        .o_rd_top  (w_rd_top),
        .o_rd_next (w_rd_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_count         <= '0;
            r_alu_a         <= '0;
            r_alu_b         <= '0;
            r_alu_op        <= OP_NOP;
            r_ovf           <= 1'b0;
            r_err_underflow <= 1'b0;
            r_err_full      <= 1'b0;
            r_err_badop     <= 1'b0;
`ifdef RPN_DIV0_TRAP_EN
            r_err_div0      <= 1'b0;
`endif
        end else begin
            r_err_underflow <= 1'b0;
            r_err_full      <= 1'b0;
            r_err_badop     <= 1'b0;
`ifdef RPN_DIV0_TRAP_EN
            r_err_div0      <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_push) begin
                            if (r_count == FULL_CNT) begin
                                r_err_full <= 1'b1;
                            end else begin
                                r_count <= r_count + 1'b1;
                            end
                        end else if (w_bad) begin
                            r_err_badop <= 1'b1;
                        end else if (w_under) begin
                            r_err_underflow <= 1'b1;
`ifdef RPN_DIV0_TRAP_EN
                        end else if (w_div0) begin
                            r_err_div0 <= 1'b1;
`endif
                        end else begin
                            r_alu_a  <= w_rd_next;
                            r_alu_b  <= w_rd_top;
                            r_alu_op <= cmd_op;
                            r_state  <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    r_count  <= r_count - 1'b1;
                    r_ovf    <= alu_ovf;
                    r_alu_op <= OP_NOP;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = (r_state == IDLE);
    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign alu_op        = r_alu_op;
    assign top           = (r_count == '0) ? '0 : w_rd_top;
    assign count         = r_count;
    assign ovf_flag      = r_ovf;
    assign err_underflow = r_err_underflow;
    assign err_full      = r_err_full;
    assign err_badop     = r_err_badop;
`ifdef RPN_DIV0_TRAP_EN
    assign err_div0      = r_err_div0;
`endif

endmodule
